// File: rtl/conv_stream_pkg.sv
// Shared types and constants for the conv layer input stream feeder.
package conv_stream_pkg;

  localparam int unsigned WORD_W = 16;
  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_e;

  // Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10)
  localparam int unsigned        LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/conv_feeder_ram.sv
// Word store for the stream feeder: one write port, one synchronous read port (1-cycle latency).
module conv_feeder_ram #(
  parameter int unsigned T       = 16,
  parameter int unsigned NUMVALS = 9984,
  parameter int unsigned AW      = $clog2(NUMVALS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [T-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [T-1:0]  rd
);

  logic [T-1:0] mem [NUMVALS];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/conv_stream_feeder.sv
// Streams words 0..len-1 from an internal RAM onto a valid/ready interface via a 2-entry FIFO.
// Optional CONV_FEEDER_THROTTLE_EN gates new valids with an LFSR bit.
module conv_stream_feeder
  import conv_stream_pkg::*;
#(
  parameter int unsigned       T       = 16,
  parameter int unsigned       NUMVALS = 9984,
  parameter int unsigned       AW      = $clog2(NUMVALS),
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic [T-1:0]  m_data_out_x,
  output logic          m_valid_x,
  input  logic          m_ready_x,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] MAXLEN = (AW+1)'(NUMVALS);

  feeder_state_e state, state_nxt;
  logic [AW:0]   len_q, issue_ptr, len_clamped;
  logic          inflight, issue, push, pop, last_xfer;
  logic [T-1:0]  fifo [2];
  logic          rd_idx, wr_idx;
  logic [1:0]    count;
  logic [T-1:0]  ram_rdata;

  assign len_clamped = (len > MAXLEN) ? MAXLEN : len;
  assign push        = inflight;
  assign pop         = m_valid_x & m_ready_x;
  // Counting this cycle's pop as a freed slot keeps the stream at one word per cycle.
  assign issue       = (state == RUN) && (issue_ptr < len_q) &&
                       (({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(pop)));
  assign last_xfer   = pop && (count == 2'd1) && !inflight && (issue_ptr == len_q);

  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign m_data_out_x = fifo[rd_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (last_xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      issue_ptr <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      rd_idx    <= 1'b0;
      wr_idx    <= 1'b0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
    end else begin
      inflight <= issue;
      if (state == IDLE && start) begin
        len_q     <= len_clamped;
        issue_ptr <= '0;
      end else if (issue) begin
        issue_ptr <= issue_ptr + (AW+1)'(1);
      end
      if (push) begin
        fifo[wr_idx] <= ram_rdata;
        wr_idx       <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      count <= count + 2'(push) - 2'(pop);
    end
  end

`ifdef CONV_FEEDER_THROTTLE_EN
  logic [LFSR_W-1:0] lfsr;
  logic              hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
      hold <= 1'b0;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
      hold <= m_valid_x & ~m_ready_x;
    end
  end

  // A stalled valid is held regardless of the LFSR so it is never withdrawn.
  assign m_valid_x = (count != '0) && (hold || lfsr[0]);
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
  assign m_valid_x   = (count != '0);
`endif

  conv_feeder_ram #(
    .T       (T),
    .NUMVALS (NUMVALS),
    .AW      (AW)
  ) u_ram (
    .clk (clk),
    .we  (wr_en && (state != RUN)),
    .wa  (wr_addr),
    .wd  (wr_data),
    .re  (issue),
    .ra  (issue_ptr[AW-1:0]),
    .rd  (ram_rdata)
  );

endmodule
